opb_register_ppc2user: RTL and testbench

OPB_REGISTER_PPC2USER -- requirements
Module: opb_register_ppc2user

---
 rtl/opb_reg_pkg.sv | 21 ++
 rtl/opb_be_merge.sv | 23 ++
 rtl/opb_register_ppc2user.sv | 154 +++++++++++++++
 tb/tb_opb_register_ppc2user.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/opb_reg_pkg.sv
// Shared FSM encoding and STATUS word layout for the PPC-to-user OPB register.
package opb_reg_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam int STATUS_COUNT_W     = 16;
  localparam int STATUS_PENDING_BIT = 16;

  // STATUS word in user bit order: [15:0] write count, [16] pending, rest zero.
  function automatic logic [31:0] status_word(input logic [STATUS_COUNT_W-1:0] count,
                                              input logic                      pending);
    logic [31:0] word;
    word                     = 32'h0000_0000;
    word[STATUS_COUNT_W-1:0] = count;
    word[STATUS_PENDING_BIT] = pending;
    return word;
  endfunction

endpackage

// File: rtl/opb_be_merge.sv
// Byte-enable merge in OPB bit order: byte k spans bits 8k..8k+7, enabled by be[k].
module opb_be_merge #(
  parameter int DWIDTH = 32
) (
  input  logic [0:DWIDTH-1]   old_word,
  input  logic [0:DWIDTH-1]   new_word,
  input  logic [0:DWIDTH/8-1] be,
  output logic [0:DWIDTH-1]   merged
);

  // Select each byte from the new word where its enable is set.
  always_comb begin
    merged = old_word;
    for (int k = 0; k < DWIDTH / 8; k++) begin
      if (be[k]) begin
        merged[8*k +: 8] = new_word[8*k +: 8];
      end else begin
        merged[8*k +: 8] = old_word[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/opb_register_ppc2user.sv
// OPB slave exposing one writable DATA word to user logic plus a read-only STATUS word
// (write count and pending flag); every hit is acked one cycle after it is sampled.
module opb_register_ppc2user
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR    = 32'h0118_8200,
  parameter logic [31:0] C_HIGHADDR    = 32'h0118_82FF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter              C_FAMILY      = "virtex6",
  parameter logic [31:0] C_RESET_VALUE = 32'h0000_0000
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [31:0]               user_data_out,
  output logic                      user_data_valid,
  input  logic                      user_ack
);

  localparam int BE_W = C_OPB_DWIDTH / 8;
  localparam int unused_family_len = $bits(C_FAMILY);

  logic [1:0]                state_r;
  logic [1:0]                state_nxt_s;
  logic                      hit_s;
  logic [C_OPB_AWIDTH-1:0]   offset_s;
  logic                      status_sel_r;
  logic                      rnw_r;
  logic [0:BE_W-1]           be_r;
  logic [0:C_OPB_DWIDTH-1]   wdata_r;
  logic [0:C_OPB_DWIDTH-1]   data_r;
  logic [0:C_OPB_DWIDTH-1]   merged_s;
  logic [0:C_OPB_DWIDTH-1]   read_word_s;
  logic [STATUS_COUNT_W-1:0] write_count_r;
  logic                      pending_r;
  logic                      valid_r;
  logic                      commit_s;
  logic                      unused_s;

  assign hit_s    = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign offset_s = OPB_ABus - C_BASEADDR;
  assign unused_s = ^{OPB_seqAddr, offset_s[C_OPB_AWIDTH-1:3], offset_s[1:0]};

  // Only a DATA write with at least one enabled byte changes any user-visible state.
  assign commit_s = (state_r == ST_ACK) && !rnw_r && !status_sel_r && (|be_r);

  opb_be_merge #(.DWIDTH(C_OPB_DWIDTH)) u_be_merge (
    .old_word (data_r),
    .new_word (wdata_r),
    .be       (be_r),
    .merged   (merged_s)
  );

  // Next-state logic: an accepted hit always runs IDLE -> ACK -> HOLD -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hit_s) begin
          state_nxt_s = ST_ACK;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACK:  state_nxt_s = ST_HOLD;
      ST_HOLD: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture the request on the accepting edge so the bus may change during ACK.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      status_sel_r <= 1'b0;
      rnw_r        <= 1'b1;
      be_r         <= '0;
      wdata_r      <= '0;
    end else if ((state_r == ST_IDLE) && hit_s) begin
      status_sel_r <= offset_s[2];
      rnw_r        <= OPB_RNW;
      be_r         <= OPB_BE;
      wdata_r      <= OPB_DBus;
    end else begin
      status_sel_r <= status_sel_r;
      rnw_r        <= rnw_r;
      be_r         <= be_r;
      wdata_r      <= wdata_r;
    end
  end

  // Commit DATA writes at the end of ACK; a coincident user_ack loses to the new write.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      data_r        <= C_RESET_VALUE;
      write_count_r <= '0;
      pending_r     <= 1'b0;
      valid_r       <= 1'b0;
    end else if (commit_s) begin
      data_r        <= merged_s;
      write_count_r <= write_count_r + 16'd1;
      pending_r     <= 1'b1;
      valid_r       <= 1'b1;
    end else begin
      valid_r <= 1'b0;
      if (user_ack) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  // Read mux driven onto the OR-bus only while acking a read.
  always_comb begin
    if (status_sel_r) begin
      read_word_s = status_word(write_count_r, pending_r);
    end else begin
      read_word_s = data_r;
    end
    if ((state_r == ST_ACK) && rnw_r) begin
      Sl_DBus = read_word_s;
    end else begin
      Sl_DBus = '0;
    end
  end

  assign Sl_xferAck      = (state_r == ST_ACK);
  assign Sl_errAck       = 1'b0;
  assign Sl_retry        = 1'b0;
  assign Sl_toutSup      = 1'b0;
  assign user_data_out   = data_r;
  assign user_data_valid = valid_r;

endmodule

// File: tb/tb_opb_register_ppc2user.sv
// Directed bench: stimulus pushes expected ack data / valid-pulse values into queues,
// independent negedge monitors pop and compare whenever the DUT presents them.
module tb_opb_register_ppc2user;

  localparam logic [31:0] BASE = 32'h0118_8200;
  localparam logic [31:0] HIGH = 32'h0118_82FF;
  localparam logic [31:0] RSTV = 32'h0BAD_F00D;

  logic        OPB_Clk = 1'b0;
  logic        OPB_Rst = 1'b1;
  logic [0:31] OPB_ABus = 32'h0;
  logic [0:3]  OPB_BE = 4'h0;
  logic [0:31] OPB_DBus = 32'h0;
  logic        OPB_RNW = 1'b1;
  logic        OPB_select = 1'b0;
  logic        OPB_seqAddr = 1'b0;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
  logic [31:0] user_data_out;
  logic        user_data_valid;
  logic        user_ack = 1'b0;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;
  logic [31:0] sb_q[$];
  logic [31:0] vq[$];

  opb_register_ppc2user #(.C_RESET_VALUE(RSTV)) dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
    .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select),
    .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck),
    .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
    .user_data_out(user_data_out), .user_data_valid(user_data_valid), .user_ack(user_ack)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus monitor: every ack consumes one scoreboard entry; bus idles at zero otherwise.
  always @(negedge OPB_Clk) begin
    if (mon_en) begin
      if (Sl_xferAck) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          check("ack_dbus", Sl_DBus, sb_q.pop_front());
        end
      end else begin
        check("idle_dbus", Sl_DBus, 32'h0);
      end
      check("const_flags", {29'h0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'h0);
    end
  end

  // User-side monitor: each valid pulse consumes one expected data value.
  always @(negedge OPB_Clk) begin
    if (mon_en && user_data_valid) begin
      if (vq.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        check("user_data_out", user_data_out, vq.pop_front());
      end
    end
  end

  // One OPB access; exp is the read data, or the committed word when pulse=1.
  task automatic xfer(input logic rnw, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] exp, input logic pulse,
                      input logic ua, input logic rst_in_ack);
    int lat;
    bit got;
    sb_q.push_back(rnw ? exp : 32'h0);
    if (pulse) vq.push_back(exp);
    @(posedge OPB_Clk); #1;
    OPB_select = 1'b1; OPB_ABus = addr; OPB_RNW = rnw; OPB_DBus = wd; OPB_BE = be;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 8) begin
      @(posedge OPB_Clk); #1;
      lat++;
      if (Sl_xferAck) got = 1'b1;
    end
    check("ack_latency", lat, 32'd1);
    if (ua) user_ack = 1'b1;
    if (rst_in_ack) OPB_Rst = 1'b1;
    @(posedge OPB_Clk); #1;
    OPB_select = 1'b0; user_ack = 1'b0;
    if (rst_in_ack) begin
      OPB_Rst = 1'b0;
      check("ack_after_reset", Sl_xferAck, 32'd0);
    end
  endtask

  task automatic pulse_user_ack();
    @(posedge OPB_Clk); #1; user_ack = 1'b1;
    @(posedge OPB_Clk); #1; user_ack = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    int acks;
    repeat (3) @(posedge OPB_Clk);
    #1; OPB_Rst = 1'b0;
    check("reset_ack", Sl_xferAck, 32'd0);
    check("reset_valid", user_data_valid, 32'd0);
    check("reset_data", user_data_out, RSTV);
    mon_en = 1'b1;

    // Reset landing in ACK aborts the write.
    xfer(1'b0, BASE, 32'h1234_5678, 4'b1111, 32'h0, 1'b0, 1'b0, 1'b1);
    xfer(1'b1, BASE,     32'h0, 4'b1111, RSTV,         1'b0, 1'b0, 1'b0);
    xfer(1'b1, BASE + 4, 32'h0, 4'b1111, 32'h0000_0000, 1'b0, 1'b0, 1'b0);

    xfer(1'b0, BASE, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    xfer(1'b1, BASE + 4, 32'h0, 4'b1111, 32'h0001_0001, 1'b0, 1'b0, 1'b0);
    xfer(1'b1, BASE,     32'h0, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);

    xfer(1'b0, BASE, 32'h1122_3344, 4'b0101, 32'hDE22_BE44, 1'b1, 1'b0, 1'b0);
    xfer(1'b1, BASE,     32'h0, 4'b1111, 32'hDE22_BE44, 1'b0, 1'b0, 1'b0);
    xfer(1'b1, BASE + 4, 32'h0, 4'b1111, 32'h0001_0002, 1'b0, 1'b0, 1'b0);

    // Zero byte enables and STATUS writes are acked but change nothing.
    xfer(1'b0, BASE,     32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0);
    xfer(1'b0, BASE + 4, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b0, 1'b0, 1'b0);
    xfer(1'b1, BASE,     32'h0, 4'b1111, 32'hDE22_BE44, 1'b0, 1'b0, 1'b0);
    xfer(1'b1, BASE + 4, 32'h0, 4'b1111, 32'h0001_0002, 1'b0, 1'b0, 1'b0);

    pulse_user_ack();
    xfer(1'b1, BASE + 4, 32'h0, 4'b1111, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    // user_ack coincident with the commit: pending must stay set.
    xfer(1'b0, BASE, 32'hCAFE_F00D, 4'b1000, 32'hCA22_BE44, 1'b1, 1'b1, 1'b0);
    xfer(1'b1, BASE + 4, 32'h0, 4'b1111, 32'h0001_0003, 1'b0, 1'b0, 1'b0);
    pulse_user_ack();
    xfer(1'b1, BASE + 4, 32'h0, 4'b1111, 32'h0000_0003, 1'b0, 1'b0, 1'b0);

    // Preload the counter near its limit to reach the wrap quickly.
    @(posedge OPB_Clk); #1;
    force dut.write_count_r = 16'hFFFE;
    #1;
    release dut.write_count_r;
    xfer(1'b0, BASE, 32'h0000_5500, 4'b0010, 32'hCA22_5544, 1'b1, 1'b0, 1'b0);
    xfer(1'b1, BASE + 4, 32'h0, 4'b1111, 32'h0001_FFFF, 1'b0, 1'b0, 1'b0);
    xfer(1'b0, BASE, 32'h0000_0099, 4'b0001, 32'hCA22_5599, 1'b1, 1'b0, 1'b0);
    xfer(1'b1, BASE + 4, 32'h0, 4'b1111, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    // Window edges: offset 8 decodes as DATA, the last word as STATUS.
    xfer(1'b1, BASE + 8,    32'h0, 4'b1111, 32'hCA22_5599, 1'b0, 1'b0, 1'b0);
    xfer(1'b1, HIGH - 3,    32'h0, 4'b1111, 32'h0001_0000, 1'b0, 1'b0, 1'b0);

    // Select held high outside the window, then in-window with select low.
    acks = 0;
    @(posedge OPB_Clk); #1;
    OPB_select = 1'b1; OPB_RNW = 1'b1; OPB_ABus = HIGH + 1;
    repeat (6) begin @(posedge OPB_Clk); #1; if (Sl_xferAck) acks++; end
    OPB_ABus = BASE - 4;
    repeat (6) begin @(posedge OPB_Clk); #1; if (Sl_xferAck) acks++; end
    OPB_select = 1'b0; OPB_ABus = BASE;
    repeat (6) begin @(posedge OPB_Clk); #1; if (Sl_xferAck) acks++; end
    check("no_ack_outside", acks, 32'd0);
    check("data_unchanged", user_data_out, 32'hCA22_5599);

    repeat (3) @(posedge OPB_Clk);
    #1;
    check("sb_drained", sb_q.size(), 32'd0);
    check("valid_drained", vq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
